// File: rtl/alu_arbiter.sv
// alu_arbiter
//
// Shares one ALU between two requesters (port 0: execute stage, port 1: branch/address unit).
// A single registered issue stage drives the ALU; each requester owns one registered response
// slot, so each port has at most one transaction outstanding. ALU op encoding is passed through
// unchanged: 00 AND, 01 OR, 10 ADD, 11 SUB.
//
// Build option:
//   ALU_ARB_RR_EN  defined   -> round-robin on ties, using last_grant (reset to 1: port 0 first)
//                  undefined -> fixed priority, port 0 wins whenever eligible
//
// Ports:
//   clk, rst                        clock (rising edge), asynchronous active-high reset
//   reqN_valid/ready/a/b/op         request N handshake and operands (N = 0, 1)
//   rspN_valid/ready/data/zero      response N handshake, result and zero flag
//   alu_read1, alu_read2, alu_ops   ALU operands and operation (0 when the issue stage is empty)
//   alu_out, alu_zero               combinational ALU result and zero flag

module alu_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [1:0]       req0_op,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [1:0]       req1_op,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp0_zero,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             rsp1_zero,

    output logic [WIDTH-1:0] alu_read1,
    output logic [WIDTH-1:0] alu_read2,
    output logic [1:0]       alu_ops,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero
);

    // Issue stage
    logic             issue_valid_q, issue_valid_d;
    logic             issue_id_q, issue_id_d;
    logic [WIDTH-1:0] issue_a_q, issue_a_d;
    logic [WIDTH-1:0] issue_b_q, issue_b_d;
    logic [1:0]       issue_op_q, issue_op_d;

    // Response slots
    logic             rsp0_valid_q, rsp0_valid_d;
    logic [WIDTH-1:0] rsp0_data_q, rsp0_data_d;
    logic             rsp0_zero_q, rsp0_zero_d;
    logic             rsp1_valid_q, rsp1_valid_d;
    logic [WIDTH-1:0] rsp1_data_q, rsp1_data_d;
    logic             rsp1_zero_q, rsp1_zero_d;

`ifdef ALU_ARB_RR_EN
    // Port id of the most recent accept
    logic             last_grant_q, last_grant_d;
`endif

    logic busy0, busy1;
    logic elig0, elig1;
    logic win0, win1;
    logic accept0, accept1;

    // Arbitration
    always_comb begin
        busy0 = (issue_valid_q && (issue_id_q == 1'b0)) || rsp0_valid_q;
        busy1 = (issue_valid_q && (issue_id_q == 1'b1)) || rsp1_valid_q;
        elig0 = req0_valid && !busy0;
        elig1 = req1_valid && !busy1;
`ifdef ALU_ARB_RR_EN
        // On a tie the port that did not win last time goes first.
        win0  = elig0 && (!elig1 || last_grant_q);
        win1  = elig1 && (!elig0 || !last_grant_q);
`else
        win0  = elig0;
        win1  = elig1 && !elig0;
`endif
        req0_ready = win0 && !rst;
        req1_ready = win1 && !rst;
        accept0    = req0_valid && req0_ready;
        accept1    = req1_valid && req1_ready;
    end

    // Next-state
    always_comb begin
        issue_valid_d = accept0 || accept1;
        issue_id_d    = issue_id_q;
        issue_a_d     = issue_a_q;
        issue_b_d     = issue_b_q;
        issue_op_d    = issue_op_q;
        if (accept0) begin
            issue_id_d = 1'b0;
            issue_a_d  = req0_a;
            issue_b_d  = req0_b;
            issue_op_d = req0_op;
        end else if (accept1) begin
            issue_id_d = 1'b1;
            issue_a_d  = req1_a;
            issue_b_d  = req1_b;
            issue_op_d = req1_op;
        end

        rsp0_valid_d = rsp0_valid_q;
        rsp0_data_d  = rsp0_data_q;
        rsp0_zero_d  = rsp0_zero_q;
        rsp1_valid_d = rsp1_valid_q;
        rsp1_data_d  = rsp1_data_q;
        rsp1_zero_d  = rsp1_zero_q;

        if (rsp0_ready) begin
            rsp0_valid_d = 1'b0;
        end
        if (rsp1_ready) begin
            rsp1_valid_d = 1'b0;
        end
        // A write into a slot never coincides with that slot being valid (busy blocks it),
        // so placing the write after the clear is purely defensive.
        if (issue_valid_q && (issue_id_q == 1'b0)) begin
            rsp0_valid_d = 1'b1;
            rsp0_data_d  = alu_out;
            rsp0_zero_d  = alu_zero;
        end
        if (issue_valid_q && (issue_id_q == 1'b1)) begin
            rsp1_valid_d = 1'b1;
            rsp1_data_d  = alu_out;
            rsp1_zero_d  = alu_zero;
        end

`ifdef ALU_ARB_RR_EN
        last_grant_d = last_grant_q;
        if (accept0) begin
            last_grant_d = 1'b0;
        end else if (accept1) begin
            last_grant_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_valid_q <= 1'b0;
            issue_id_q    <= 1'b0;
            issue_a_q     <= '0;
            issue_b_q     <= '0;
            issue_op_q    <= 2'b00;
            rsp0_valid_q  <= 1'b0;
            rsp0_data_q   <= '0;
            rsp0_zero_q   <= 1'b0;
            rsp1_valid_q  <= 1'b0;
            rsp1_data_q   <= '0;
            rsp1_zero_q   <= 1'b0;
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_id_q    <= issue_id_d;
            issue_a_q     <= issue_a_d;
            issue_b_q     <= issue_b_d;
            issue_op_q    <= issue_op_d;
            rsp0_valid_q  <= rsp0_valid_d;
            rsp0_data_q   <= rsp0_data_d;
            rsp0_zero_q   <= rsp0_zero_d;
            rsp1_valid_q  <= rsp1_valid_d;
            rsp1_data_q   <= rsp1_data_d;
            rsp1_zero_q   <= rsp1_zero_d;
        end
    end

`ifdef ALU_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    // Outputs
    always_comb begin
        alu_read1  = issue_valid_q ? issue_a_q  : '0;
        alu_read2  = issue_valid_q ? issue_b_q  : '0;
        alu_ops    = issue_valid_q ? issue_op_q : 2'b00;
        rsp0_valid = rsp0_valid_q;
        rsp0_data  = rsp0_data_q;
        rsp0_zero  = rsp0_zero_q;
        rsp1_valid = rsp1_valid_q;
        rsp1_data  = rsp1_data_q;
        rsp1_zero  = rsp1_zero_q;
    end

endmodule
